ulpi_pkt_scheduler: RTL and testbench

ULPI_PKT_SCHEDULER -- requirements
Module: ulpi_pkt_scheduler

---
 rtl/ulpi_pkt_scheduler.sv | 127 ++++++++++++
 tb/tb_ulpi_pkt_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_pkt_scheduler.sv
// Drains INFO/DATA receive buffers into framed byte stream: SYNC, info hi, info lo, payload.
// Payload length comes from the INFO word, clamped to MAX_LEN; pkt_count tallies completed frames.
module ulpi_pkt_scheduler #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [9:0] MAX_LEN   = 10'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        info_empty,
  input  logic        info_full,
  input  logic [15:0] info_data,
  output logic        info_re,
  input  logic        data_empty,
  input  logic        data_full,
  input  logic [7:0]  data_in,
  output logic        data_re,
  output logic        read_allow,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] pkt_count,
  output logic        len_err
);

  localparam int unsigned INFO_W = 16;
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    IDLE, INFO_RD, INFO_WAIT, HDR0, HDR1, HDR2, DATA_RD, DATA_WAIT, DATA_OUT
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [INFO_W-1:0]   info_q;
  logic [CNT_W-1:0]    remaining;
  logic                accept;
  logic                frame_done;
  logic                present_next;
  logic                info_over;

  assign info_over = (info_data[CNT_W-1:0] > MAX_LEN);

  // Pop follows the live empty flag so a stalled read never pops an empty buffer.
  assign data_re = !rst && (state == DATA_RD) && !data_empty;

  // Next-state decode
  always_comb begin
    state_next   = state;
    frame_done   = 1'b0;
    accept       = tx_valid && tx_ready;
    unique case (state)
      IDLE:      if (enable && !info_empty) state_next = INFO_RD;
      INFO_RD:   state_next = INFO_WAIT;
      INFO_WAIT: state_next = HDR0;
      HDR0:      if (accept) state_next = HDR1;
      HDR1:      if (accept) state_next = HDR2;
      HDR2: begin
        if (accept) begin
          if (remaining == CNT_W'(0)) begin
            state_next = IDLE;
            frame_done = 1'b1;
          end else begin
            state_next = DATA_RD;
          end
        end
      end
      DATA_RD:   if (!data_empty) state_next = DATA_WAIT;
      DATA_WAIT: state_next = DATA_OUT;
      DATA_OUT: begin
        if (accept) begin
          if (remaining == CNT_W'(1)) begin
            state_next = IDLE;
            frame_done = 1'b1;
          end else begin
            state_next = DATA_RD;
          end
        end
      end
      default:   state_next = IDLE;
    endcase
    present_next = (state_next == HDR0) || (state_next == HDR1) ||
                   (state_next == HDR2) || (state_next == DATA_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Registered outputs and frame datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      info_re    <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= BYTE_W'(0);
      read_allow <= 1'b0;
      pkt_count  <= 16'd0;
      len_err    <= 1'b0;
      info_q     <= INFO_W'(0);
      remaining  <= CNT_W'(0);
    end else begin
      info_re    <= (state_next == INFO_RD);
      tx_valid   <= present_next;
      read_allow <= enable && !info_full && !data_full;
      if (state == INFO_WAIT) begin
        info_q    <= info_data;
        remaining <= info_over ? MAX_LEN : info_data[CNT_W-1:0];
        if (info_over) len_err <= 1'b1;
      end
      if ((state == DATA_OUT) && accept) remaining <= remaining - CNT_W'(1);
      if (frame_done) pkt_count <= pkt_count + 16'd1;
      // Load tx_data only on entry to a presenting state so it holds across stalls.
      if (state_next != state) begin
        unique case (state_next)
          HDR0:     tx_data <= SYNC_BYTE;
          HDR1:     tx_data <= info_q[15:8];
          HDR2:     tx_data <= info_q[7:0];
          DATA_OUT: tx_data <= data_in;
          default:  tx_data <= tx_data;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ulpi_pkt_scheduler.sv
// Directed + randomized bench for ulpi_pkt_scheduler: buffers and sink are modelled in the bench,
// and the expected byte stream is built frame by frame from the header/clamp rules.
module tb_ulpi_pkt_scheduler;

  localparam logic [7:0] SYNC    = 8'hA5;
  localparam logic [9:0] MAXL    = 10'd512;

  logic        clk = 1'b0;
  logic        rst, enable, info_empty, info_full, data_empty, data_full, tx_ready;
  logic [15:0] info_data;
  logic [7:0]  data_in;
  logic        info_re, data_re, read_allow, tx_valid, len_err;
  logic [7:0]  tx_data;
  logic [15:0] pkt_count;

  ulpi_pkt_scheduler #(.SYNC_BYTE(SYNC), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .info_empty(info_empty), .info_full(info_full), .info_data(info_data), .info_re(info_re),
    .data_empty(data_empty), .data_full(data_full), .data_in(data_in), .data_re(data_re),
    .read_allow(read_allow), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .pkt_count(pkt_count), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] ififo[$];
  logic [7:0]  dfifo[$];
  logic [7:0]  fb[$];
  logic [8:0]  exp_q[$];
  int          accept_cyc[$];
  logic [15:0] exp_pkts = 16'd0;
  int          exp_info_re = 0, exp_data_re = 0, obs_info_re = 0, obs_data_re = 0;
  logic        exp_len_err = 1'b0;
  int          got_total = 0, cyc = 0, ready_mode = 2;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic refresh();
    info_empty = (ififo.size() == 0);
    data_empty = (dfifo.size() == 0);
  endtask

  // Expected stream for one frame: header always as received, payload clamped to MAXL bytes of fb.
  task automatic expect_frame(input logic [15:0] info);
    int n;
    n = (info[9:0] > MAXL) ? int'(MAXL) : int'(info[9:0]);
    exp_q.push_back({1'b0, SYNC});
    exp_q.push_back({1'b0, info[15:8]});
    exp_q.push_back({1'b0, info[7:0]});
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, fb[i]});
    exp_pkts    = exp_pkts + 16'd1;
    exp_info_re = exp_info_re + 1;
    exp_data_re = exp_data_re + n;
    if (info[9:0] > MAXL) exp_len_err = 1'b1;
  endtask

  task automatic send(input logic [15:0] info, input int push_n);
    for (int i = 0; i < push_n; i++) dfifo.push_back(fb[i]);
    ififo.push_back(info);
    expect_frame(info);
    refresh();
  endtask

  task automatic rand_fb(input int n);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
  endtask

  // One clock: observe at negedge, update buffer/sink models just after posedge.
  task automatic cycle();
    logic s_info_re, s_data_re;
    logic [8:0] want;
    @(negedge clk);
    s_info_re = info_re;
    s_data_re = data_re;
    if (info_re || data_re) begin
      chk("re_exclusive", 32'(info_re && data_re), 32'd0);
      chk("re_while_empty", 32'((info_re && info_empty) || (data_re && data_empty)), 32'd0);
    end
    if (prev_valid && !prev_ready && !rst) begin
      chk("hold_valid", 32'(tx_valid), 32'd1);
      chk("hold_data", 32'(tx_data), 32'(prev_data));
    end
    if (tx_valid && tx_ready) begin
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h100;
      chk("tx_byte", 32'({1'b0, tx_data}), 32'(want));
      accept_cyc.push_back(cyc);
      got_total++;
    end
    if (info_re) obs_info_re++;
    if (data_re) obs_data_re++;
    prev_valid = tx_valid;
    prev_ready = tx_ready;
    prev_data  = tx_data;
    @(posedge clk);
    #1;
    cyc++;
    if (s_info_re && ififo.size() > 0) info_data = ififo.pop_front();
    if (s_data_re && dfifo.size() > 0) data_in = dfifo.pop_front();
    refresh();
    if (ready_mode == 0) tx_ready = 1'b1;
    else if (ready_mode == 1) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_got(input string tag, input int target, input int budget);
    int n = 0;
    while (got_total < target && n < budget) begin cycle(); n++; end
    chk(tag, 32'(got_total >= target), 32'd1);
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || pkt_count !== exp_pkts) && n < budget) begin cycle(); n++; end
    repeat (4) cycle();
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_pkts"}, 32'(pkt_count), 32'(exp_pkts));
    chk({tag, "_info_re"}, 32'(obs_info_re), 32'(exp_info_re));
    chk({tag, "_data_re"}, 32'(obs_data_re), 32'(exp_data_re));
    chk({tag, "_len_err"}, 32'(len_err), 32'(exp_len_err));
    chk({tag, "_idle"}, 32'(tx_valid), 32'd0);
  endtask

  initial begin
    int base, d0, i0, n;
    logic [15:0] p0;
    rst = 1'b1; enable = 1'b0; info_full = 1'b0; data_full = 1'b0;
    tx_ready = 1'b0; info_data = 16'h0; data_in = 8'h0;
    refresh();

    // Reset state
    repeat (2) cycle();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_info_re", 32'(info_re), 32'd0);
    chk("rst_data_re", 32'(data_re), 32'd0);
    chk("rst_read_allow", 32'(read_allow), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    rst = 1'b0; enable = 1'b1;
    cycle();
    chk("read_allow_on", 32'(read_allow), 32'd1);

    // Basic frame with 3 payload bytes, sink always ready
    ready_mode = 0; tx_ready = 1'b1;
    accept_cyc.delete();
    fb.delete(); fb.push_back(8'h11); fb.push_back(8'h22); fb.push_back(8'h33);
    send(16'h0403, 3);
    run_until_done("basic", 100);
    chk("throughput", 32'((accept_cyc.size() >= 6) && ((accept_cyc[5] - accept_cyc[2]) <= 9)), 32'd1);

    // Zero-length frame with event bits set
    fb.delete();
    send(16'hFC00, 0);
    run_until_done("zero_len", 50);

    // Sink stalls 5 cycles while the second header byte is offered
    ready_mode = 2; tx_ready = 1'b1;
    rand_fb(2);
    base = got_total;
    send(16'h2802, 2);
    wait_got("reach_hdr1", base + 1, 50);
    tx_ready = 1'b0;
    repeat (5) cycle();
    chk("stall_valid", 32'(tx_valid), 32'd1);
    chk("stall_data", 32'(tx_data), 32'h28);
    ready_mode = 0; tx_ready = 1'b1;
    run_until_done("sink_stall", 100);

    // DATA buffer runs dry after the first of three bytes
    rand_fb(3);
    base = got_total;
    send(16'h0003, 1);
    wait_got("first_byte", base + 4, 50);
    d0 = obs_data_re;
    repeat (10) cycle();
    chk("dry_valid", 32'(tx_valid), 32'd0);
    chk("dry_no_pop", 32'(obs_data_re), 32'(d0));
    dfifo.push_back(fb[1]); dfifo.push_back(fb[2]); refresh();
    run_until_done("data_dry", 100);

    // enable dropped mid-frame with a second frame queued
    p0 = exp_pkts;
    rand_fb(4);
    send(16'h1004, 4);
    rand_fb(2);
    send(16'h2002, 2);
    base = got_total;
    i0 = obs_info_re;
    wait_got("byte2_of_4", base + 4, 50);
    enable = 1'b0;
    n = 0;
    while (pkt_count !== p0 + 16'd1 && n < 50) begin cycle(); n++; end
    repeat (10) cycle();
    chk("dis_pkts", 32'(pkt_count), 32'(p0 + 16'd1));
    chk("dis_no_pop", 32'(obs_info_re), 32'(i0 + 1));
    chk("dis_idle", 32'(tx_valid), 32'd0);
    chk("dis_read_allow", 32'(read_allow), 32'd0);
    enable = 1'b1;
    cycle();
    chk("en_read_allow", 32'(read_allow), 32'd1);
    data_full = 1'b1;
    cycle();
    chk("full_read_allow", 32'(read_allow), 32'd0);
    data_full = 1'b0;
    run_until_done("enable_drop", 100);

    // Randomized frames against a randomly stalling sink
    ready_mode = 1;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(0, 8);
      rand_fb(n);
      send({6'($urandom), 10'(n)}, n);
    end
    run_until_done("random", 1500);

    // Reset while a payload byte is being offered
    ready_mode = 2; tx_ready = 1'b1;
    rand_fb(4);
    base = got_total;
    send(16'h0004, 4);
    wait_got("rst_frame_b1", base + 4, 50);
    tx_ready = 1'b0;
    n = 0;
    while (!tx_valid && n < 10) begin cycle(); n++; end
    chk("reach_data_out", 32'(tx_valid), 32'd1);
    rst = 1'b1;
    cycle();
    chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("mid_rst_info_re", 32'(info_re), 32'd0);
    chk("mid_rst_data_re", 32'(data_re), 32'd0);
    chk("mid_rst_read_allow", 32'(read_allow), 32'd0);
    chk("mid_rst_len_err", 32'(len_err), 32'd0);
    rst = 1'b0;
    ififo.delete(); dfifo.delete(); exp_q.delete(); refresh();
    exp_pkts = 16'd0; exp_info_re = 0; exp_data_re = 0; exp_len_err = 1'b0;
    obs_info_re = 0; obs_data_re = 0; prev_valid = 1'b0;

    // Oversized count: header unmodified, payload clamped, sticky len_err
    ready_mode = 0; tx_ready = 1'b1;
    rand_fb(int'(MAXL));
    send(16'hFFFF, int'(MAXL));
    run_until_done("len_clamp", 2500);
    chk("len_err_sticky", 32'(len_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
